// File: rtl/piso_tx.sv
// piso_tx: parallel-in/serial-out transmitter. Words arrive over valid/ready and leave on a registered tx line.
// Optional macro PARITY_EN adds an even-parity bit after the data bits.
module piso_tx #(
    parameter int DATA_W = 8,
    parameter int DIV    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_l2b,
    output logic              tx,
    output logic              tx_active,
    output logic              done
);
    localparam int DIV_CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_CW = $clog2(DATA_W);
    localparam logic [DIV_CW-1:0] DIV_LAST = DIV_CW'(DIV - 1);
    localparam logic [DIV_CW-1:0] DIV_ZERO = {DIV_CW{1'b0}};
    localparam logic [BIT_CW-1:0] BIT_LAST = BIT_CW'(DATA_W - 1);
    localparam logic [BIT_CW-1:0] BIT_ZERO = {BIT_CW{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_GAP    = 2'd2
`ifdef PARITY_EN
        , S_PARITY = 2'd3
`endif
    } state_e;

    state_e            state_q, state_d;
    logic [DIV_CW-1:0] div_q, div_d;
    logic [BIT_CW-1:0] bit_q, bit_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic              order_q, order_d;
    logic              tx_q, tx_d;
    logic              tx_active_q, tx_active_d;
    logic              done_q, done_d;
    logic              in_ready_q, in_ready_d;
`ifdef PARITY_EN
    logic              par_q, par_d;
`endif

    logic accept_s;
    logic div_last_s;
    logic bit_last_s;

    function automatic logic head_bit(input logic [DATA_W-1:0] d, input logic msb_first);
        return msb_first ? d[DATA_W-1] : d[0];
    endfunction

    // The shift register always presents the next bit at the end it was loaded towards.
    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] d, input logic msb_first);
        return msb_first ? {d[DATA_W-2:0], 1'b0} : {1'b0, d[DATA_W-1:1]};
    endfunction

`ifdef PARITY_EN
    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction
`endif

    assign accept_s   = in_valid & in_ready_q;
    assign div_last_s = (div_q == DIV_LAST);
    assign bit_last_s = (bit_q == BIT_LAST);

    assign in_ready  = in_ready_q;
    assign tx        = tx_q;
    assign tx_active = tx_active_q;
    assign done      = done_q;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) state_d = S_SHIFT;
                else          state_d = S_IDLE;
            end
            S_SHIFT: begin
                if (div_last_s && bit_last_s) begin
`ifdef PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_GAP;
`endif
                end else begin
                    state_d = S_SHIFT;
                end
            end
`ifdef PARITY_EN
            S_PARITY: begin
                if (div_last_s) state_d = S_GAP;
                else            state_d = S_PARITY;
            end
`endif
            S_GAP: begin
                if (div_last_s) state_d = S_IDLE;
                else            state_d = S_GAP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs, registered one cycle ahead from the next state.
    always_comb begin
        tx_active_d = 1'b0;
        done_d      = 1'b0;
        in_ready_d  = 1'b0;
`ifdef PARITY_EN
        tx_active_d = (state_d == S_SHIFT) || (state_d == S_PARITY);
`else
        tx_active_d = (state_d == S_SHIFT);
`endif
        done_d      = (state_d == S_GAP) && (state_q != S_GAP);
        in_ready_d  = (state_d == S_IDLE);
    end

    // Datapath: divider, bit counter, shift register and the next tx value.
    always_comb begin
        div_d   = div_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        order_d = order_q;
        tx_d    = 1'b0;
`ifdef PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                div_d = DIV_ZERO;
                bit_d = BIT_ZERO;
                if (accept_s) begin
                    sr_d    = shift_out(in_data, in_l2b);
                    order_d = in_l2b;
                    tx_d    = head_bit(in_data, in_l2b);
`ifdef PARITY_EN
                    par_d   = even_parity(in_data);
`endif
                end else begin
                    tx_d = 1'b0;
                end
            end
            S_SHIFT: begin
                if (div_last_s) begin
                    div_d = DIV_ZERO;
                    if (bit_last_s) begin
                        bit_d = BIT_ZERO;
`ifdef PARITY_EN
                        tx_d  = par_q;
`else
                        tx_d  = 1'b0;
`endif
                    end else begin
                        bit_d = bit_q + BIT_CW'(1'b1);
                        tx_d  = head_bit(sr_q, order_q);
                        sr_d  = shift_out(sr_q, order_q);
                    end
                end else begin
                    div_d = div_q + DIV_CW'(1'b1);
                    tx_d  = tx_q;
                end
            end
`ifdef PARITY_EN
            S_PARITY: begin
                if (div_last_s) begin
                    div_d = DIV_ZERO;
                    tx_d  = 1'b0;
                end else begin
                    div_d = div_q + DIV_CW'(1'b1);
                    tx_d  = tx_q;
                end
            end
`endif
            S_GAP: begin
                tx_d = 1'b0;
                if (div_last_s) div_d = DIV_ZERO;
                else            div_d = div_q + DIV_CW'(1'b1);
            end
            default: begin
                div_d = DIV_ZERO;
                bit_d = BIT_ZERO;
                tx_d  = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; tx leaves the block straight from tx_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q       <= DIV_ZERO;
            bit_q       <= BIT_ZERO;
            sr_q        <= {DATA_W{1'b0}};
            order_q     <= 1'b0;
            tx_q        <= 1'b0;
            tx_active_q <= 1'b0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            div_q       <= div_d;
            bit_q       <= bit_d;
            sr_q        <= sr_d;
            order_q     <= order_d;
            tx_q        <= tx_d;
            tx_active_q <= tx_active_d;
            done_q      <= done_d;
            in_ready_q  <= in_ready_d;
`ifdef PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: random and directed frames checked cycle by cycle against a frame-level model.
module tb_piso_tx;
    localparam int DATA_W = 8;
    localparam int DIV    = 4;
`ifdef PARITY_EN
    localparam int FR = (DATA_W + 2) * DIV;
`else
    localparam int FR = (DATA_W + 1) * DIV;
`endif
    localparam int MAXC = 256;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_l2b = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready, tx, tx_active, done;

    int tests_run    = 0;
    int tests_failed = 0;

    logic exp_tx [MAXC];
    logic exp_act[MAXC];
    logic exp_dn [MAXC];
    logic exp_rdy[MAXC];
    logic obs_tx [MAXC];
    logic obs_act[MAXC];
    logic obs_dn [MAXC];
    logic obs_rdy[MAXC];

    piso_tx #(.DATA_W(DATA_W), .DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_l2b   (in_l2b),
        .tx       (tx),
        .tx_active(tx_active),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Expected per-cycle outputs of one frame; cycle base+1 is the first cycle after the accepting edge.
    task automatic build_expected(input logic [DATA_W-1:0] d, input logic l2b, input int base);
        int c;
        logic b;
        c = base + 1;
        for (int k = 0; k < DATA_W; k++) begin
            b = l2b ? d[DATA_W-1-k] : d[k];
            for (int j = 0; j < DIV; j++) begin
                exp_tx[c] = b; exp_act[c] = 1'b1; exp_dn[c] = 1'b0; exp_rdy[c] = 1'b0; c++;
            end
        end
`ifdef PARITY_EN
        for (int j = 0; j < DIV; j++) begin
            exp_tx[c] = ^d; exp_act[c] = 1'b1; exp_dn[c] = 1'b0; exp_rdy[c] = 1'b0; c++;
        end
`endif
        for (int j = 0; j < DIV; j++) begin
            exp_tx[c] = 1'b0; exp_act[c] = 1'b0; exp_dn[c] = (j == 0); exp_rdy[c] = 1'b0; c++;
        end
        exp_tx[c] = 1'b0; exp_act[c] = 1'b0; exp_dn[c] = 1'b0; exp_rdy[c] = 1'b1;
    endtask

    task automatic start_frame(input logic [DATA_W-1:0] d, input logic l);
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_l2b = l;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Record n cycles; inputs are scrambled, and with poke a fresh word is offered while busy.
    task automatic capture(input int n, input bit poke);
        for (int i = 1; i <= n; i++) begin
            obs_tx[i] = tx; obs_act[i] = tx_active; obs_dn[i] = done; obs_rdy[i] = in_ready;
            in_l2b   = 1'($urandom_range(0, 1));
            in_data  = DATA_W'($urandom);
            in_valid = poke && (i < FR);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({tx, tx_active, done, in_ready} !== 4'b0001) begin
            tests_failed++;
            $display("FAIL reset_hold tx/act/done/rdy got %b%b%b%b exp 0001", tx, tx_active, done, in_ready);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if ({tx, tx_active, done, in_ready} !== 4'b0001) begin
            tests_failed++;
            $display("FAIL reset_release tx/act/done/rdy got %b%b%b%b exp 0001", tx, tx_active, done, in_ready);
        end
    endtask

    task automatic test_lsb_first();
        start_frame(8'h0F, 1'b0);
        build_expected(8'h0F, 1'b0, 0);
        capture(FR + 1, 1'b0);
        for (int i = 1; i <= FR + 1; i++) begin
            tests_run++;
            if ({obs_tx[i], obs_act[i], obs_dn[i], obs_rdy[i]} !== {exp_tx[i], exp_act[i], exp_dn[i], exp_rdy[i]}) begin
                tests_failed++;
                $display("FAIL lsb_first cyc %0d tx/act/done/rdy got %b%b%b%b exp %b%b%b%b", i,
                         obs_tx[i], obs_act[i], obs_dn[i], obs_rdy[i], exp_tx[i], exp_act[i], exp_dn[i], exp_rdy[i]);
            end
        end
        tests_run++;
        if (obs_dn[FR - DIV + 1] !== 1'b1 || obs_rdy[FR + 1] !== 1'b1 || obs_rdy[FR] !== 1'b0) begin
            tests_failed++;
            $display("FAIL lsb_timing done@%0d got %b exp 1, rdy@%0d got %b exp 1, rdy@%0d got %b exp 0",
                     FR - DIV + 1, obs_dn[FR - DIV + 1], FR + 1, obs_rdy[FR + 1], FR, obs_rdy[FR]);
        end
    endtask

    task automatic test_msb_first();
        start_frame(8'h0F, 1'b1);
        build_expected(8'h0F, 1'b1, 0);
        capture(FR + 1, 1'b1);
        for (int i = 1; i <= FR + 1; i++) begin
            tests_run++;
            if ({obs_tx[i], obs_act[i], obs_dn[i], obs_rdy[i]} !== {exp_tx[i], exp_act[i], exp_dn[i], exp_rdy[i]}) begin
                tests_failed++;
                $display("FAIL msb_first cyc %0d tx/act/done/rdy got %b%b%b%b exp %b%b%b%b", i,
                         obs_tx[i], obs_act[i], obs_dn[i], obs_rdy[i], exp_tx[i], exp_act[i], exp_dn[i], exp_rdy[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] d;
        logic l;
        bit poke;
        for (int f = 0; f < 6; f++) begin
            d    = DATA_W'($urandom);
            l    = 1'($urandom_range(0, 1));
            poke = 1'($urandom_range(0, 1));
            start_frame(d, l);
            build_expected(d, l, 0);
            capture(FR + 1, poke);
            for (int i = 1; i <= FR + 1; i++) begin
                tests_run++;
                if ({obs_tx[i], obs_act[i], obs_dn[i], obs_rdy[i]} !== {exp_tx[i], exp_act[i], exp_dn[i], exp_rdy[i]}) begin
                    tests_failed++;
                    $display("FAIL random frame %0d data %h l2b %b cyc %0d got %b%b%b%b exp %b%b%b%b", f, d, l, i,
                             obs_tx[i], obs_act[i], obs_dn[i], obs_rdy[i], exp_tx[i], exp_act[i], exp_dn[i], exp_rdy[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] word;
        logic [DATA_W-1:0] want;
        logic              ord;
        int                b;
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h81; in_l2b = 1'b0;
        @(posedge clk); #1;
        build_expected(8'h81, 1'b0, 0);
        build_expected(8'h7E, 1'b1, FR + 1);
        for (int i = 1; i <= 2 * FR + 2; i++) begin
            obs_tx[i] = tx; obs_act[i] = tx_active; obs_dn[i] = done; obs_rdy[i] = in_ready;
            if (i == 1) begin in_data = 8'h7E; in_l2b = 1'b1; end
            if (i == FR + 2) in_valid = 1'b0;
            @(posedge clk); #1;
        end
        for (int i = 1; i <= 2 * FR + 2; i++) begin
            tests_run++;
            if ({obs_tx[i], obs_act[i], obs_dn[i], obs_rdy[i]} !== {exp_tx[i], exp_act[i], exp_dn[i], exp_rdy[i]}) begin
                tests_failed++;
                $display("FAIL back_to_back cyc %0d tx/act/done/rdy got %b%b%b%b exp %b%b%b%b", i,
                         obs_tx[i], obs_act[i], obs_dn[i], obs_rdy[i], exp_tx[i], exp_act[i], exp_dn[i], exp_rdy[i]);
            end
        end
        // Reassemble each word the way a mid-bit sampling receiver would.
        for (int f = 0; f < 2; f++) begin
            b    = (f == 0) ? 0 : FR + 1;
            ord  = (f == 0) ? 1'b0 : 1'b1;
            want = (f == 0) ? 8'h81 : 8'h7E;
            word = '0;
            for (int k = 0; k < DATA_W; k++) begin
                if (ord) word[DATA_W-1-k] = obs_tx[b + 1 + k * DIV + DIV / 2];
                else     word[k]          = obs_tx[b + 1 + k * DIV + DIV / 2];
            end
            tests_run++;
            if (word !== want) begin
                tests_failed++;
                $display("FAIL b2b_reassemble frame %0d got %h exp %h", f, word, want);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [DATA_W-1:0] d;
        start_frame(8'hFF, 1'b0);
        repeat (13) begin @(posedge clk); #1; end
        tests_run++;
        if ({tx, tx_active} !== 2'b11) begin
            tests_failed++;
            $display("FAIL midframe_pre tx/act got %b%b exp 11", tx, tx_active);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({tx, tx_active, done, in_ready} !== 4'b0001) begin
            tests_failed++;
            $display("FAIL midframe_abort tx/act/done/rdy got %b%b%b%b exp 0001", tx, tx_active, done, in_ready);
        end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 2 * DIV; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if ({tx, tx_active, done, in_ready} !== 4'b0001) begin
                tests_failed++;
                $display("FAIL after_abort cyc %0d tx/act/done/rdy got %b%b%b%b exp 0001", i, tx, tx_active, done, in_ready);
            end
        end
        d = DATA_W'($urandom);
        start_frame(d, 1'b0);
        build_expected(d, 1'b0, 0);
        capture(FR + 1, 1'b0);
        for (int i = 1; i <= FR + 1; i++) begin
            tests_run++;
            if ({obs_tx[i], obs_act[i], obs_dn[i], obs_rdy[i]} !== {exp_tx[i], exp_act[i], exp_dn[i], exp_rdy[i]}) begin
                tests_failed++;
                $display("FAIL post_abort_frame data %h cyc %0d got %b%b%b%b exp %b%b%b%b", d, i,
                         obs_tx[i], obs_act[i], obs_dn[i], obs_rdy[i], exp_tx[i], exp_act[i], exp_dn[i], exp_rdy[i]);
            end
        end
    endtask

`ifdef PARITY_EN
    task automatic test_parity();
        start_frame(8'h07, 1'b0);
        capture(FR + 1, 1'b0);
        for (int i = DATA_W * DIV + 1; i <= DATA_W * DIV + DIV; i++) begin
            tests_run++;
            if ({obs_tx[i], obs_act[i]} !== 2'b11) begin
                tests_failed++;
                $display("FAIL parity_07 cyc %0d tx/act got %b%b exp 11", i, obs_tx[i], obs_act[i]);
            end
        end
        tests_run++;
        if (obs_dn[37] !== 1'b1 || obs_dn[33] !== 1'b0 || obs_rdy[41] !== 1'b1 || obs_rdy[40] !== 1'b0) begin
            tests_failed++;
            $display("FAIL parity_timing done33 %b done37 %b rdy40 %b rdy41 %b exp 0 1 0 1",
                     obs_dn[33], obs_dn[37], obs_rdy[40], obs_rdy[41]);
        end
        start_frame(8'h03, 1'b1);
        capture(FR + 1, 1'b0);
        for (int i = DATA_W * DIV + 1; i <= DATA_W * DIV + DIV; i++) begin
            tests_run++;
            if ({obs_tx[i], obs_act[i]} !== 2'b01) begin
                tests_failed++;
                $display("FAIL parity_03 cyc %0d tx/act got %b%b exp 01", i, obs_tx[i], obs_act[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_random();
        test_back_to_back();
        test_reset_midframe();
`ifdef PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
